// File: rtl/lfsr_seq_gen_if.sv
// Handshake bundle between the LFSR sequence generator and its seed source / consumer.
// The master side offers seeds and accepts output words; the slave side is the generator.
interface lfsr_seq_gen_if #(
    parameter int WIDTH = 4
);
    logic             seed_valid;
    logic [WIDTH-1:0] seed;
    logic             seed_ready;
    logic             seed_err;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_bit;
    logic             wrap;
    logic [WIDTH-1:0] period;

    modport master (
        output seed_valid, seed, out_ready,
        input  seed_ready, seed_err, out_valid, out_data, out_bit, wrap, period
    );

    modport slave (
        input  seed_valid, seed, out_ready,
        output seed_ready, seed_err, out_valid, out_data, out_bit, wrap, period
    );
endinterface

// File: rtl/lfsr_seq_gen.sv
// Fibonacci LFSR register stage with seed load, valid/ready output streaming
// and period tracking (wrap pulse when the state returns to the loaded seed).
module lfsr_seq_gen #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = 4'b1100
) (
    input  logic          clk,
    input  logic          rst_n,
    lfsr_seq_gen_if.slave bus
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_t;

    fsm_t             fsm_reg;
    logic [WIDTH-1:0] state_reg;
    logic [WIDTH-1:0] seed_reg;
    logic [WIDTH-1:0] step_cnt_reg;
    logic [WIDTH-1:0] period_reg;
    logic             out_valid_reg;
    logic             wrap_reg;
    logic             seed_err_reg;

    logic             feedback;
    logic [WIDTH-1:0] shift_next;
    logic [WIDTH-1:0] seed_fixed;
    logic             step_fire;

    // Shift network: bit gi takes bit gi-1, bit 0 takes the tap parity.
    assign feedback      = ^(state_reg & TAPS);
    assign shift_next[0] = feedback;
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_shift
        assign shift_next[gi] = state_reg[gi-1];
    end

    // An all-zero seed would lock the register up, so it is replaced by 1.
    assign seed_fixed = (bus.seed == '0) ? WIDTH'(1) : bus.seed;
    assign step_fire  = (fsm_reg == RUN) && out_valid_reg && bus.out_ready;

    // Sequencer: seed load has priority over a step; wrap and seed_err are one-cycle pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_reg       <= IDLE;
            state_reg     <= '0;
            seed_reg      <= '0;
            step_cnt_reg  <= '0;
            period_reg    <= '0;
            out_valid_reg <= 1'b0;
            wrap_reg      <= 1'b0;
            seed_err_reg  <= 1'b0;
        end else begin
            wrap_reg     <= 1'b0;
            seed_err_reg <= 1'b0;
            case (fsm_reg)
                IDLE: begin
                    if (bus.seed_valid) begin
                        fsm_reg       <= RUN;
                        state_reg     <= seed_fixed;
                        seed_reg      <= seed_fixed;
                        step_cnt_reg  <= '0;
                        out_valid_reg <= 1'b1;
                        seed_err_reg  <= (bus.seed == '0);
                    end
                end
                RUN: begin
                    if (bus.seed_valid) begin
                        // A concurrent step still counts as a transfer, but the
                        // register takes the new seed and no wrap is reported.
                        state_reg     <= seed_fixed;
                        seed_reg      <= seed_fixed;
                        step_cnt_reg  <= '0;
                        out_valid_reg <= 1'b1;
                        seed_err_reg  <= (bus.seed == '0);
                    end else if (step_fire) begin
                        state_reg <= shift_next;
                        if (shift_next == seed_reg) begin
                            wrap_reg     <= 1'b1;
                            period_reg   <= step_cnt_reg + WIDTH'(1);
                            step_cnt_reg <= '0;
                        end else begin
                            step_cnt_reg <= step_cnt_reg + WIDTH'(1);
                        end
                    end
                end
                default: fsm_reg <= IDLE;
            endcase
        end
    end

    // Every output comes straight from a register; no input reaches an output combinationally.
    assign bus.seed_ready = 1'b1;
    assign bus.seed_err   = seed_err_reg;
    assign bus.out_valid  = out_valid_reg;
    assign bus.out_data   = state_reg;
    assign bus.out_bit    = state_reg[WIDTH-1];
    assign bus.wrap       = wrap_reg;
    assign bus.period     = period_reg;

endmodule

// File: tb/tb_lfsr_seq_gen.sv
// Self-checking bench for lfsr_seq_gen (WIDTH=4, TAPS=4'b1100): directed steps
// followed by randomized traffic, compared against a behavioural reference model.
module tb_lfsr_seq_gen;

    localparam int W    = 4;
    localparam int TAPS = 'b1100;

    logic clk;
    logic rst_n;

    lfsr_seq_gen_if #(.WIDTH(W)) bus ();

    lfsr_seq_gen #(.WIDTH(W), .TAPS(4'b1100)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_valid;
    int m_state;
    int m_seed;
    int m_steps;
    int m_period;
    int m_wrap;
    int m_err;

    // Next LFSR value from the rule: shift left, bring in parity of tapped bits.
    function automatic int lfsr_next(input int s);
        int ones;
        ones = $countones(s & TAPS);
        return ((s * 2) + (ones % 2)) % (1 << W);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, sample outputs 1 time unit after the edge.
    task automatic cyc(input logic rstn, input logic sv, input int sd, input logic rdy);
        int nxt;
        rst_n          = rstn;
        bus.seed_valid = sv;
        bus.seed       = sd[W-1:0];
        bus.out_ready  = rdy;
        if (!rstn) begin
            m_valid = 0; m_state = 0; m_seed = 0; m_steps = 0;
            m_period = 0; m_wrap = 0; m_err = 0;
        end else if (sv) begin
            m_seed  = (sd % 16 == 0) ? 1 : sd % 16;
            m_state = m_seed;
            m_steps = 0;
            m_valid = 1;
            m_err   = (sd % 16 == 0);
            m_wrap  = 0;
        end else begin
            m_err  = 0;
            m_wrap = 0;
            if (m_valid != 0 && rdy) begin
                nxt     = lfsr_next(m_state);
                m_state = nxt;
                if (nxt == m_seed) begin
                    m_wrap   = 1;
                    m_period = (m_steps + 1) % 16;
                    m_steps  = 0;
                end else begin
                    m_steps = (m_steps + 1) % 16;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", int'(bus.out_valid), m_valid);
        chk("out_data",  int'(bus.out_data),  m_state);
        chk("out_bit",   int'(bus.out_bit),   (m_state >> (W - 1)) & 1);
        chk("wrap",      int'(bus.wrap),      m_wrap);
        chk("seed_err",  int'(bus.seed_err),  m_err);
        chk("period",    int'(bus.period),    m_period);
        chk("seed_ready", int'(bus.seed_ready), 1);
        $display("cyc rst_n=%0b sv=%0b seed=%0h rdy=%0b -> valid=%0b data=%0h wrap=%0b err=%0b period=%0d",
                 rstn, sv, sd[W-1:0], rdy, bus.out_valid, bus.out_data, bus.wrap, bus.seed_err, bus.period);
    endtask

    int seq_tbl [16] = '{1, 2, 4, 9, 3, 6, 'hD, 'hA, 5, 'hB, 7, 'hF, 'hE, 'hC, 8, 1};

    initial begin
        rst_n          = 1'b0;
        bus.seed_valid = 1'b0;
        bus.seed       = '0;
        bus.out_ready  = 1'b0;

        // Reset
        cyc(1'b0, 1'b0, 0, 1'b0);
        cyc(1'b0, 1'b0, 0, 1'b1);
        chk("reset_valid",  int'(bus.out_valid), 0);
        chk("reset_period", int'(bus.period), 0);

        // Idle with ready high: nothing streams without a seed
        cyc(1'b1, 1'b0, 0, 1'b1);

        // Seed 1
        cyc(1'b1, 1'b1, 1, 1'b0);
        chk("seed1_data", int'(bus.out_data), 1);
        chk("seed1_err",  int'(bus.seed_err), 0);

        // Full period with ready held, against the known sequence
        for (int i = 1; i < 16; i++) begin
            cyc(1'b1, 1'b0, 0, 1'b1);
            chk("seq_tbl", int'(bus.out_data), seq_tbl[i]);
            chk("seq_wrap", int'(bus.wrap), (i == 15) ? 1 : 0);
        end
        chk("period15", int'(bus.period), 15);

        // Advance to state 4, then ready 1,0,0,1 -> 9,9,9,3
        cyc(1'b1, 1'b0, 0, 1'b1);
        cyc(1'b1, 1'b0, 0, 1'b1);
        chk("at4", int'(bus.out_data), 4);
        cyc(1'b1, 1'b0, 0, 1'b1);
        cyc(1'b1, 1'b0, 0, 1'b0);
        cyc(1'b1, 1'b0, 0, 1'b0);
        chk("stall_data", int'(bus.out_data), 9);
        chk("stall_valid", int'(bus.out_valid), 1);
        cyc(1'b1, 1'b0, 0, 1'b1);
        chk("after_stall", int'(bus.out_data), 3);

        // Zero seed -> substituted by 1 with error pulse
        cyc(1'b1, 1'b1, 0, 1'b0);
        chk("zero_seed_err",  int'(bus.seed_err), 1);
        chk("zero_seed_data", int'(bus.out_data), 1);
        cyc(1'b1, 1'b0, 0, 1'b1);
        chk("zero_err_drop", int'(bus.seed_err), 0);
        chk("zero_restart",  int'(bus.out_data), 2);

        // Seed 6 together with an accepted step (state 2 would shift to 4)
        cyc(1'b1, 1'b1, 6, 1'b1);
        chk("seed_beats_step", int'(bus.out_data), 6);
        chk("seed_step_wrap",  int'(bus.wrap), 0);
        // 14 steps reach 3, whose successor is the seed 6
        for (int i = 0; i < 14; i++) cyc(1'b1, 1'b0, 0, 1'b1);
        chk("pre_seed_state", int'(bus.out_data), 3);
        // Reload 6 on that very step: no wrap even though the shift would hit the seed
        cyc(1'b1, 1'b1, 6, 1'b1);
        chk("reload_no_wrap", int'(bus.wrap), 0);
        // step_cnt restarted at 0: wrap after exactly 15 steps
        for (int i = 0; i < 15; i++) cyc(1'b1, 1'b0, 0, 1'b1);
        chk("wrap_after_reload", int'(bus.wrap), 1);

        // Reset mid-run
        cyc(1'b1, 1'b0, 0, 1'b1);
        cyc(1'b0, 1'b0, 0, 1'b1);
        chk("midrst_valid",  int'(bus.out_valid), 0);
        chk("midrst_period", int'(bus.period), 0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 0, 1'b1);
        chk("midrst_idle", int'(bus.out_valid), 0);
        cyc(1'b1, 1'b1, 'hB, 1'b1);
        chk("midrst_reseed", int'(bus.out_data), 'hB);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic r_rstn;
            logic r_sv;
            logic r_rdy;
            int   r_sd;
            r_rstn = ($urandom % 60) != 0;
            r_sv   = ($urandom % 12) == 0;
            r_sd   = ($urandom % 5 == 0) ? 0 : int'($urandom % 16);
            r_rdy  = ($urandom % 3) != 0;
            cyc(r_rstn, r_sv, r_sd, r_rdy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
